weight_update_sequencer: RTL
============================

// Module: weight_update_sequencer
// PURPOSE
//  Streams every (weight, error) pair of the 2-32-32-3 DQN into update_weight: output layer, then hidden 2, then hidden 1.
//  Captures each o_new_weight and writes it back to the matching weight RAM and address.
//  Sits between the weight/error RAMs and update_weight; started once per training step by the DQN top controller.
// PARAMETERS
//  DATA_WIDTH   32    weight/error word width (FP32 bit pattern, passed through untouched)
//  ADDR_WIDTH   12    width of all RAM addresses
//  N_OUT_W      99    output-layer weights (3*33)
//  N_HID2_W     1056  hidden-2 weights (32*33)
//  N_HID1_W     96    hidden-1 weights (32*3)
// PORTS
//  clk               in   1           system clock, rising edge
//  rst               in   1           asynchronous reset, active-high
//  i_start           in   1           one-cycle pulse; begin a full update pass
//  o_busy            out  1           high from start accept until done
//  o_done            out  1           one-cycle pulse when last write-back completes
//  o_err_rd_addr     out  ADDR_WIDTH  error RAM read address (global index 0..1250)
//  i_err_rd_data     in   DATA_WIDTH  error RAM data, valid 1 cycle after address
//  o_w_rd_sel        out  2           weight read layer: 0=output, 1=hidden2, 2=hidden1
//  o_w_rd_addr       out  ADDR_WIDTH  weight read address within selected layer
//  i_w_rd_data       in   DATA_WIDTH  selected weight RAM data, valid 1 cycle after address
//  o_upd_valid       out  1           to update_weight i_valid
//  o_upd_weight      out  DATA_WIDTH  to update_weight i_weight
//  o_upd_error       out  DATA_WIDTH  to update_weight i_error
//  i_upd_valid       in   1           from update_weight o_valid
//  i_upd_new_weight  in   DATA_WIDTH  from update_weight o_new_weight
//  o_w_wr_en         out  1           weight RAM write strobe
//  o_w_wr_sel        out  2           write layer, same encoding as o_w_rd_sel
//  o_w_wr_addr       out  ADDR_WIDTH  write address within layer
//  o_w_wr_data       out  DATA_WIDTH  new weight
//  o_overflow        out  1           sticky: i_upd_valid seen with no write-back outstanding
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0, o_overflow cleared. Reset mid-pass aborts; no further writes issued.
//  Read FSM: IDLE -> RD_OUT -> RD_HID2 -> RD_HID1 -> WAIT_WB -> IDLE.
//   - i_start in IDLE: accept, o_busy=1 next cycle. i_start while busy is ignored.
//   - One read issued per cycle, no gaps. Global index g runs 0..1250; o_err_rd_addr=g.
//   - Layer address runs 0..N-1 per layer, then resets to 0 and sel advances. No idle cycle at layer boundaries.
//   - Issue cycles: 1..1251 after accept.
//  Read pipeline: issue addr at t; RAM data at t+1; registered into o_upd_* with o_upd_valid=1 at t+2.
//   - First o_upd_valid 3 cycles after accept; 1251 consecutive valid cycles.
//   - o_upd_weight/o_upd_error hold last value when o_upd_valid=0.
//  Write-back (independent of update_weight latency, in-order return assumed):
//   - Each i_upd_valid: registered write next cycle with o_w_wr_en=1 and data=i_upd_new_weight.
//   - sel/addr come from a write-side counter with the same layer walk as the read side.
//   - Same-layer read/write hazard impossible: write of addr a always follows read of a.
//  Done: after the 1251st write-back, o_done pulses with that write, then o_busy=0 and FSM returns to IDLE.
//   - i_start accepted on the cycle after o_done.
//  Overflow: i_upd_valid while write count already 1251, or in IDLE, sets o_overflow; no write is issued.
//   - o_overflow clears only on rst.
//  Width: N_OUT_W+N_HID2_W+N_HID1_W must fit ADDR_WIDTH (1251 < 4096).
// STRUCTURE
//  Package dqn_weight_pkg: layer size constants (99/1056/96), total 1251, LAYER_OUT/HID2/HID1 sel encodings.
//  Sub-module layer_addr_counter: given advance, emits sel, in-layer addr, and last flag.
//   - Instantiated twice: read side and write side.
// TESTING
//  Pulse i_start, update_weight model with fixed 6-cycle latency
//   -> first o_upd_valid 3 cycles after accept; exactly 1251 writes, sel/addr order 0:0..98, 1:0..1055, 2:0..95; one o_done.
//  RAMs preloaded with weight=addr, error=g
//   -> o_upd_weight/o_upd_error match at every valid, including cycles g=98/99 and 1154/1155 (layer boundaries).
//  Model returns i_upd_new_weight = weight+1
//   -> every RAM location incremented by exactly 1 after o_done; no location written twice.
//  i_start re-pulsed at cycle 500 of a pass -> ignored; count and sequence unchanged.
//  Assert rst at cycle 700, release, restart -> outputs 0 during reset; new pass completes with 1251 writes.
//  Extra i_upd_valid after o_done -> o_overflow=1, o_w_wr_en stays 0.

Source files
------------

// File: rtl/dqn_weight_pkg.sv
// Shared layer geometry, layer-select encodings and sequencer states for the DQN
// weight-update path (2-32-32-3 network).
package dqn_weight_pkg;

  localparam int unsigned N_OUT_W   = 99;
  localparam int unsigned N_HID2_W  = 1056;
  localparam int unsigned N_HID1_W  = 96;
  localparam int unsigned N_TOTAL_W = N_OUT_W + N_HID2_W + N_HID1_W;

  localparam logic [1:0] LAYER_OUT  = 2'd0;
  localparam logic [1:0] LAYER_HID2 = 2'd1;
  localparam logic [1:0] LAYER_HID1 = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StRdOut,
    StRdHid2,
    StRdHid1,
    StWaitWb
  } wus_state_e;

  // Walk order is output -> hidden 2 -> hidden 1, wrapping back to output.
  function automatic logic [1:0] next_layer(input logic [1:0] sel);
    return (sel == LAYER_HID1) ? LAYER_OUT : sel + 2'd1;
  endfunction

endpackage

// File: rtl/layer_addr_counter.sv
// Walks (layer select, in-layer address) pairs in update order; one step per advance.
// last flags the final address of the current layer.
module layer_addr_counter
  import dqn_weight_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [1:0]            sel,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [1:0]            sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] last_addr;

  always_comb begin
    last_addr = '0;
    case (sel_q)
      LAYER_OUT:  last_addr = ADDR_WIDTH'(N_OUT_W - 1);
      LAYER_HID2: last_addr = ADDR_WIDTH'(N_HID2_W - 1);
      LAYER_HID1: last_addr = ADDR_WIDTH'(N_HID1_W - 1);
      default:    last_addr = '0;
    endcase
  end

  assign last = (addr_q == last_addr);
  assign sel  = sel_q;
  assign addr = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= LAYER_OUT;
      addr_q <= '0;
    end else if (clear) begin
      sel_q  <= LAYER_OUT;
      addr_q <= '0;
    end else if (advance) begin
      if (last) begin
        addr_q <= '0;
        sel_q  <= next_layer(sel_q);
      end else begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/weight_update_sequencer.sv
// Streams every (weight, error) pair into update_weight and writes each returned weight
// back to its layer RAM; one full pass per start pulse.
module weight_update_sequencer
  import dqn_weight_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_err_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_err_rd_data,
  output logic [1:0]            o_w_rd_sel,
  output logic [ADDR_WIDTH-1:0] o_w_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_w_rd_data,
  output logic                  o_upd_valid,
  output logic [DATA_WIDTH-1:0] o_upd_weight,
  output logic [DATA_WIDTH-1:0] o_upd_error,
  input  logic                  i_upd_valid,
  input  logic [DATA_WIDTH-1:0] i_upd_new_weight,
  output logic                  o_w_wr_en,
  output logic [1:0]            o_w_wr_sel,
  output logic [ADDR_WIDTH-1:0] o_w_wr_addr,
  output logic [DATA_WIDTH-1:0] o_w_wr_data,
  output logic                  o_overflow
);

  wus_state_e            state_q;
  logic [ADDR_WIDTH-1:0] g_q;
  logic                  issue_d1_q;
  logic                  wb_done_q;

  logic                  start_acc;
  logic                  rd_issue;
  logic                  rd_last;
  logic                  wr_fire;
  logic                  wr_last;
  logic                  wr_layer_last;
  logic [1:0]            wr_sel;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign start_acc = (state_q == StIdle) && i_start;
  assign rd_issue  = (state_q == StRdOut) || (state_q == StRdHid2) || (state_q == StRdHid1);
  // Returns are in order, so the write-side walk alone identifies the target location.
  assign wr_fire   = i_upd_valid && (state_q != StIdle) && !wb_done_q;
  assign wr_last   = wr_layer_last && (wr_sel == LAYER_HID1);

  assign o_err_rd_addr = g_q;

  layer_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .advance (rd_issue),
    .sel     (o_w_rd_sel),
    .addr    (o_w_rd_addr),
    .last    (rd_last)
  );

  layer_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .advance (wr_fire),
    .sel     (wr_sel),
    .addr    (wr_addr),
    .last    (wr_layer_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      g_q          <= '0;
      issue_d1_q   <= 1'b0;
      wb_done_q    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_upd_valid  <= 1'b0;
      o_upd_weight <= '0;
      o_upd_error  <= '0;
      o_w_wr_en    <= 1'b0;
      o_w_wr_sel   <= '0;
      o_w_wr_addr  <= '0;
      o_w_wr_data  <= '0;
      o_overflow   <= 1'b0;
    end else begin
      // Read pipeline: address at t, RAM data at t+1, registered to update_weight at t+2.
      issue_d1_q  <= rd_issue;
      o_upd_valid <= issue_d1_q;
      if (issue_d1_q) begin
        o_upd_weight <= i_w_rd_data;
        o_upd_error  <= i_err_rd_data;
      end
      if (rd_issue) begin
        g_q <= (rd_last && (state_q == StRdHid1)) ? '0 : g_q + ADDR_WIDTH'(1);
      end

      o_w_wr_en <= wr_fire;
      o_done    <= wr_fire && wr_last;
      if (wr_fire) begin
        o_w_wr_sel  <= wr_sel;
        o_w_wr_addr <= wr_addr;
        o_w_wr_data <= i_upd_new_weight;
        if (wr_last) begin
          wb_done_q <= 1'b1;
        end
      end else if (i_upd_valid) begin
        o_overflow <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q   <= StRdOut;
            o_busy    <= 1'b1;
            wb_done_q <= 1'b0;
          end
        end
        StRdOut:  if (rd_last) state_q <= StRdHid2;
        StRdHid2: if (rd_last) state_q <= StRdHid1;
        StRdHid1: if (rd_last) state_q <= StWaitWb;
        StWaitWb: begin
          if (o_done) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end
        end
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule
